// File: rtl/word_serializer_pkg.sv
// Shared constants for the word serializer: FSM state encodings and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package word_serializer_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_CHUNK_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : word_serializer_pkg

// File: rtl/word_serializer_shreg.sv
// Loadable left-shift register that feeds the serializer's chunk output from its top bits.
// Latency: one cycle from load/shift to the new top_chunk.
// Backpressure: none locally; load and shift are gated by the owning FSM.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset (clears to zero)
//   load, load_dat       capture a fresh word (load wins over shift)
//   shift                shift left by CHUNK_W with zero fill
//   top_chunk            most significant CHUNK_W bits of the register
module word_serializer_shreg
  import word_serializer_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [WORD_W-1:0]  load_dat,
  output logic [CHUNK_W-1:0] top_chunk
);

  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_dat;
    end else if (shift) begin
      // Full-width shift keeps this valid even when the word is a single chunk.
      shreg_d = shreg_q << CHUNK_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign top_chunk = shreg_q[WORD_W-1 -: CHUNK_W];

endmodule : word_serializer_shreg

// File: rtl/word_serializer.sv
// Splits each WORD_W input word into WORD_W/CHUNK_W chunks, most significant chunk first.
// Latency: word accepted at edge N shows its first chunk in the cycle after edge N.
// Backpressure: chunks hold while out_ready=0; a new word is taken alongside the last chunk.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_valid, in_word, in_ready     upstream word handshake
//   out_valid, out_chunk, out_last  downstream chunk (out_last marks a word's final chunk)
//   out_ready                       downstream accept
//   busy                            a word is held and not fully emitted
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_word,
  output logic               in_ready,
  output logic               out_valid,
  output logic [CHUNK_W-1:0] out_chunk,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy
);

  localparam int NCHUNK = WORD_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic               in_hs;
  logic               out_hs;
  logic               sh_load;
  logic               sh_shift;
  logic [CHUNK_W-1:0] top_chunk;

  // Outputs decoded from registered state only, so in_word never reaches out_chunk
  // combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_chunk = '0;
    busy      = 1'b0;
    if (state_q == ST_SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_chunk = top_chunk;
      out_last  = (idx_q == IDX_LAST);
      // Refill in the same cycle the last chunk leaves to avoid a bubble.
      in_ready  = out_ready && out_last;
    end
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          sh_load = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_hs) begin
          if (out_last) begin
            if (in_hs) begin
              sh_load = 1'b1;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sh_shift = 1'b1;
            idx_d    = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  word_serializer_shreg #(
    .WORD_W  (WORD_W),
    .CHUNK_W (CHUNK_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_dat  (in_word),
    .top_chunk (top_chunk)
  );

endmodule : word_serializer

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL provide parameter WORD_W, default 16, meaning input word width in bits.
REQ-002 The block SHALL provide parameter CHUNK_W, default 8, meaning output chunk width in bits; WORD_W SHALL be an integer multiple of CHUNK_W, with NCHUNK = WORD_W/CHUNK_W.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  upstream word presented.
REQ-006 Port in_word  input  WORD_W  word to serialize.
REQ-007 Port in_ready  output  1  block accepts in_word this cycle.
REQ-008 Port out_valid  output  1  out_chunk holds a valid chunk.
REQ-009 Port out_chunk  output  CHUNK_W  current chunk, most significant first.
REQ-010 Port out_last  output  1  current chunk is the final chunk of its word.
REQ-011 Port out_ready  input  1  downstream accepts out_chunk this cycle.
REQ-012 Port busy  output  1  a word is held and not fully emitted.

Function
REQ-013 The block SHALL invert the slbi packing: a word W SHALL be emitted as NCHUNK chunks, high chunk first, so that repeatedly applying (acc << CHUNK_W) | chunk rebuilds W.
REQ-014 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-015 The input handshake SHALL fire when in_valid && in_ready are both high at a posedge; the output handshake SHALL fire when out_valid && out_ready are both high at a posedge.
REQ-016 In IDLE: in_ready=1, out_valid=0, busy=0; an input handshake SHALL load the shift register with in_word, clear the chunk index to 0, and move to SEND.
REQ-017 In SEND: out_valid=1, busy=1, out_chunk=shreg[WORD_W-1 -: CHUNK_W], out_last=(index==NCHUNK-1).
REQ-018 Latency: a word accepted at edge N SHALL present its first chunk with out_valid high in the cycle after edge N; no combinational path from in_word to out_chunk.
REQ-019 An output handshake with out_last=0 SHALL shift shreg left by CHUNK_W (zero-fill) and increment the index.
REQ-020 With out_valid=1 and out_ready=0, out_chunk, out_last, the index and shreg SHALL hold unchanged.
REQ-021 In SEND, in_ready SHALL equal out_ready && out_last (combinational), so that a new word can load in the same cycle the last chunk is accepted.
REQ-022 On the last-chunk handshake with a simultaneous input handshake, the block SHALL load the new word, reset the index to 0 and stay in SEND, giving NCHUNK-cycle throughput per word with no bubble.
REQ-023 On the last-chunk handshake without an input handshake, the block SHALL return to IDLE.
REQ-024 in_word SHALL be ignored when in_valid=0 or in_ready=0; the index SHALL never exceed NCHUNK-1.

Reset
REQ-025 While rst=1 at a posedge, the block SHALL enter IDLE with shreg=0, index=0, out_valid=0, out_last=0, out_chunk=0, busy=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-026 A reset during SEND SHALL discard the partial word with no further chunks emitted; rst SHALL take priority over any simultaneous handshake.

Structure
REQ-027 The IDLE/SEND state encodings and the default WORD_W/CHUNK_W values SHALL reside in the shared processor constants package/include.
REQ-028 The loadable left-shift register (load, shift enable, synchronous reset) SHALL be one sub-module, word_serializer_shreg; the FSM and index counter SHALL stay in the top module.

Verification
REQ-029 Single word: in_word=16'hA55A, out_ready=1 -> out_chunk 8'hA5 (out_last=0), then 8'h5A (out_last=1), then out_valid=0.
REQ-030 Back-to-back: words 16'h1234 and 16'hBEEF with in_valid and out_ready held at 1 -> chunks 12,34,BE,EF on four consecutive cycles; in_ready=1 in the 34 cycle.
REQ-031 Backpressure: 16'h1234 loaded, out_ready=0 for 3 cycles -> out_chunk stays 8'h12 and in_ready stays 0; out_ready=1 -> 8'h34 follows.
REQ-032 Reset mid-word: rst=1 during the 8'hDE chunk of 16'hDEAD -> 8'hAD is never emitted; out_valid=0 and in_ready=1 afterwards.
REQ-033 Round-trip: 200 $random words, each chunk pair fed through an slbi reference model ((acc<<8)|chunk) -> every rebuilt value equals the original word; out_valid random stall is allowed.
